param_miss_handler: RTL and testbench

//   Parametrised successor of the instruction-cache miss handler. Captures a lookup result and, on a miss, picks a victim way.

---
 rtl/param_miss_handler_pkg.sv | 22 ++
 rtl/param_miss_handler_if.sv | 22 ++
 rtl/param_miss_handler_victim_select.sv | 68 ++++++
 rtl/param_miss_handler.sv | 156 +++++++++++++++
 tb/tb_param_miss_handler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/param_miss_handler_pkg.sv
// Shared defaults, FSM state encoding and status-word sizing for the miss handler.
package param_miss_handler_pkg;

  localparam int WAYS_DEF   = 4;
  localparam int SET_W_DEF  = 4;
  localparam int OFF_W_DEF  = 4;
  localparam int TAG_W_DEF  = 8;
  localparam int WORD_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_META = 2'd3
  } miss_state_e;

  // One {valid, age} field per way.
  function automatic int sa_width(input int ways);
    return ways * (1 + $clog2(ways));
  endfunction

endpackage

// File: rtl/param_miss_handler_if.sv
// Memory-side request/fill channel; master is the miss handler, slave the memory.
interface param_miss_handler_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 20
);
  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;
  logic              req_ready;
  logic [WORD_W-1:0] data;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output req_addr, req_valid, data_ready,
    input  req_ready, data, data_valid
  );

  modport slave (
    input  req_addr, req_valid, data_ready,
    output req_ready, data, data_valid
  );
endinterface

// File: rtl/param_miss_handler_victim_select.sv
// Picks the victim way from a set's status word and builds the post-fill status word.
module param_miss_handler_victim_select
  import param_miss_handler_pkg::*;
#(
  parameter int WAYS = WAYS_DEF,
  localparam int AGE_W = $clog2(WAYS),
  localparam int SA_W  = sa_width(WAYS)
) (
  input  logic [SA_W-1:0] sa_i,
  output logic [WAYS-1:0] victim_o,
  output logic [SA_W-1:0] sa_next_o
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  logic [WAYS-1:0]  valid_vec;
  logic [AGE_W-1:0] age_arr [WAYS];
  logic             victim_valid;
  logic [AGE_W-1:0] victim_age;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_unpack
    assign valid_vec[gi] = sa_i[gi*(1+AGE_W) + AGE_W];
    assign age_arr[gi]   = sa_i[gi*(1+AGE_W) +: AGE_W];
  end

  // Invalid ways win first; otherwise the oldest way. Way 0 covers a malformed word.
  always_comb begin
    logic found;
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_vec[w]) begin
        victim_o[w] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && age_arr[w] == AGE_MAX) begin
        victim_o[w] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) victim_o[0] = 1'b1;
  end

  always_comb begin
    victim_valid = 1'b0;
    victim_age   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (victim_o[w]) begin
        victim_valid = valid_vec[w];
        victim_age   = age_arr[w];
      end
    end
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
    logic [AGE_W-1:0] age_inc;
    logic             ages;
    assign age_inc = (age_arr[gi] == AGE_MAX) ? AGE_MAX : age_arr[gi] + 1'b1;
    assign ages    = valid_vec[gi] && (!victim_valid || age_arr[gi] < victim_age);
    assign sa_next_o[gi*(1+AGE_W) +: (1+AGE_W)] =
        victim_o[gi] ? {1'b1, {AGE_W{1'b0}}} :
        ages         ? {1'b1, age_inc}       :
                       {valid_vec[gi], age_arr[gi]};
  end

endmodule

// File: rtl/param_miss_handler.sv
// Instruction-cache miss handler: victim pick, critical-word-first fill with early
// restart, then tag/status commit.
module param_miss_handler
  import param_miss_handler_pkg::*;
#(
  parameter int WAYS   = WAYS_DEF,
  parameter int SET_W  = SET_W_DEF,
  parameter int OFF_W  = OFF_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  localparam int SA_W  = sa_width(WAYS)
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   i_halt,
  input  logic                   i_req_valid,
  input  logic                   i_cache_hit,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic [SET_W-1:0]       i_set,
  input  logic [OFF_W-1:0]       i_off,
  input  logic [SA_W-1:0]        i_sa_data,
  output logic                   o_ready,
  param_miss_handler_if.master   mem,
  output logic [SET_W+OFF_W-1:0] o_da_addr,
  output logic [WORD_W-1:0]      o_da_data,
  output logic [WAYS-1:0]        o_da_mask,
  output logic                   o_da_valid,
  output logic [SET_W-1:0]       o_ta_addr,
  output logic [TAG_W-1:0]       o_ta_data,
  output logic [WAYS-1:0]        o_ta_mask,
  output logic                   o_ta_valid,
  output logic [SET_W-1:0]       o_sa_addr,
  output logic [SA_W-1:0]        o_sa_data,
  output logic [WAYS-1:0]        o_sa_mask,
  output logic                   o_sa_valid,
  input  logic                   i_da_halt,
  input  logic                   i_ta_halt,
  input  logic                   i_sa_halt,
  output logic                   o_miss_state,
  output logic [WORD_W-1:0]      o_missed_word,
  output logic                   o_missed_word_valid
);

  miss_state_e       state_q, state_d;
  logic [TAG_W-1:0]  tag_q;
  logic [SET_W-1:0]  set_q;
  logic [OFF_W-1:0]  crit_q;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W-1:0]  beat_q;
  logic [WAYS-1:0]   victim_q;
  logic [SA_W-1:0]   sa_next_q;
  logic              ta_done_q, sa_done_q;
  logic [WORD_W-1:0] missed_word_q;
  logic              missed_valid_q;

  logic [WAYS-1:0]   victim_w;
  logic [SA_W-1:0]   sa_next_w;
  logic              data_ready_w;
  logic              miss_accept, beat_fire, last_beat;
  logic              ta_fire, sa_fire, ta_done, sa_done;

  param_miss_handler_victim_select #(.WAYS(WAYS)) u_victim (
    .sa_i      (i_sa_data),
    .victim_o  (victim_w),
    .sa_next_o (sa_next_w)
  );

  assign miss_accept = i_req_valid & o_ready & ~i_cache_hit;
  assign beat_fire   = data_ready_w & mem.data_valid;
  assign last_beat   = (beat_q == {OFF_W{1'b1}});
  assign ta_fire     = o_ta_valid & ~i_ta_halt & ~i_halt;
  assign sa_fire     = o_sa_valid & ~i_sa_halt & ~i_halt;
  assign ta_done     = ta_done_q | ta_fire;
  assign sa_done     = sa_done_q | sa_fire;

  always_ff @(posedge clk) begin
    if (srst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // i_halt freezes the whole FSM, including pending handshakes.
  always_comb begin
    state_d = state_q;
    if (!i_halt) begin
      unique case (state_q)
        ST_IDLE: if (miss_accept)            state_d = ST_REQ;
        ST_REQ:  if (mem.req_ready)          state_d = ST_FILL;
        ST_FILL: if (beat_fire && last_beat) state_d = ST_META;
        ST_META: if (ta_done && sa_done)     state_d = ST_IDLE;
        default:                             state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready       = (state_q == ST_IDLE) & ~i_halt;
    o_miss_state  = (state_q != ST_IDLE);
    mem.req_valid = (state_q == ST_REQ);
    data_ready_w  = (state_q == ST_FILL) & ~i_da_halt & ~i_halt;
    o_da_valid    = data_ready_w & mem.data_valid;
    o_ta_valid    = (state_q == ST_META) & ~ta_done_q;
    o_sa_valid    = (state_q == ST_META) & ~sa_done_q;
    o_da_mask     = o_da_valid ? victim_q : '0;
    o_ta_mask     = o_ta_valid ? victim_q : '0;
    o_sa_mask     = o_sa_valid ? {WAYS{1'b1}} : '0;
  end

  assign mem.data_ready      = data_ready_w;
  assign mem.req_addr        = {tag_q, set_q, crit_q};
  assign o_da_addr           = {set_q, off_q};
  assign o_da_data           = mem.data;
  assign o_ta_addr           = set_q;
  assign o_ta_data           = tag_q;
  assign o_sa_addr           = set_q;
  assign o_sa_data           = sa_next_q;
  assign o_missed_word       = missed_word_q;
  assign o_missed_word_valid = missed_valid_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      tag_q          <= '0;
      set_q          <= '0;
      crit_q         <= '0;
      off_q          <= '0;
      beat_q         <= '0;
      victim_q       <= '0;
      sa_next_q      <= '0;
      ta_done_q      <= 1'b0;
      sa_done_q      <= 1'b0;
      missed_word_q  <= '0;
      missed_valid_q <= 1'b0;
    end else begin
      if (miss_accept) begin
        tag_q     <= i_tag;
        set_q     <= i_set;
        crit_q    <= i_off;
        off_q     <= i_off;
        beat_q    <= '0;
        victim_q  <= victim_w;
        sa_next_q <= sa_next_w;
        ta_done_q <= 1'b0;
        sa_done_q <= 1'b0;
      end
      // Offset wraps naturally at WORDS, giving critical-word-first order.
      if (beat_fire) begin
        off_q  <= off_q + 1'b1;
        beat_q <= beat_q + 1'b1;
      end
      if (beat_fire && beat_q == '0) missed_word_q <= mem.data;
      if (!i_halt) missed_valid_q <= beat_fire && (beat_q == '0);
      if (ta_fire) ta_done_q <= 1'b1;
      if (sa_fire) sa_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_miss_handler.sv
// Directed bench for param_miss_handler: hit, cold/LRU misses, wrap, stalls, abort.
module tb_param_miss_handler;

  logic        clk = 1'b0;
  logic        srst;
  logic        i_halt, i_req_valid, i_cache_hit;
  logic [7:0]  i_tag;
  logic [3:0]  i_set, i_off;
  logic [11:0] i_sa_data;
  logic        o_ready;
  logic [7:0]  o_da_addr;
  logic [19:0] o_da_data;
  logic [3:0]  o_da_mask;
  logic        o_da_valid;
  logic [3:0]  o_ta_addr;
  logic [7:0]  o_ta_data;
  logic [3:0]  o_ta_mask;
  logic        o_ta_valid;
  logic [3:0]  o_sa_addr;
  logic [11:0] o_sa_data;
  logic [3:0]  o_sa_mask;
  logic        o_sa_valid;
  logic        i_da_halt, i_ta_halt, i_sa_halt;
  logic        o_miss_state;
  logic [19:0] o_missed_word;
  logic        o_missed_word_valid;

  int errors = 0;
  int checks = 0;
  int da_cnt = 0;

  param_miss_handler_if #(.ADDR_W(16), .WORD_W(20)) mem_if ();

  param_miss_handler dut (
    .clk                 (clk),
    .srst                (srst),
    .i_halt              (i_halt),
    .i_req_valid         (i_req_valid),
    .i_cache_hit         (i_cache_hit),
    .i_tag               (i_tag),
    .i_set               (i_set),
    .i_off               (i_off),
    .i_sa_data           (i_sa_data),
    .o_ready             (o_ready),
    .mem                 (mem_if),
    .o_da_addr           (o_da_addr),
    .o_da_data           (o_da_data),
    .o_da_mask           (o_da_mask),
    .o_da_valid          (o_da_valid),
    .o_ta_addr           (o_ta_addr),
    .o_ta_data           (o_ta_data),
    .o_ta_mask           (o_ta_mask),
    .o_ta_valid          (o_ta_valid),
    .o_sa_addr           (o_sa_addr),
    .o_sa_data           (o_sa_data),
    .o_sa_mask           (o_sa_mask),
    .o_sa_valid          (o_sa_valid),
    .i_da_halt           (i_da_halt),
    .i_ta_halt           (i_ta_halt),
    .i_sa_halt           (i_sa_halt),
    .o_miss_state        (o_miss_state),
    .o_missed_word       (o_missed_word),
    .o_missed_word_valid (o_missed_word_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_da_valid) da_cnt <= da_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " miss_state"}, 32'(o_miss_state), 32'd0);
    check({tag, " ready"}, 32'(o_ready), 32'd1);
    check({tag, " valids"}, {27'd0, mem_if.req_valid, o_da_valid, o_ta_valid, o_sa_valid,
          o_missed_word_valid}, 32'd0);
    check({tag, " masks"}, {20'd0, o_da_mask, o_ta_mask, o_sa_mask}, 32'd0);
  endtask

  // stall_kind: 0 none, 1 i_halt, 2 i_da_halt (3 cycles before beat stall_k)
  task automatic run_miss(input logic [7:0] tag, input logic [3:0] set, input logic [3:0] off,
                          input logic [11:0] sa, input logic [3:0] exp_vic,
                          input logic [11:0] exp_sa, input logic [19:0] base,
                          input int stall_k, input int stall_kind, input bit meta_halt,
                          input int abort_at);
    int         da_start;
    logic [3:0] eo;
    da_start = da_cnt;
    @(negedge clk);
    i_req_valid = 1'b1; i_cache_hit = 1'b0;
    i_tag = tag; i_set = set; i_off = off; i_sa_data = sa;
    #1 check("accept ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_req_valid = 1'b0; i_sa_data = '0;
    #1;
    check("req valid", 32'(mem_if.req_valid), 32'd1);
    check("req addr", 32'(mem_if.req_addr), 32'({tag, set, off}));
    check("req ready low", 32'(o_ready), 32'd0);
    mem_if.req_ready = 1'b1;
    @(negedge clk);
    mem_if.req_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      eo = off + 4'(k);
      if (k == abort_at) begin
        mem_if.data_valid = 1'b0;
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        #1 check_idle("abort");
        check("abort da writes", 32'(da_cnt - da_start), 32'(abort_at));
        $display("miss tag=%0h set=%0h off=%0h aborted after %0d beats", tag, set, off, abort_at);
        return;
      end
      mem_if.data_valid = 1'b1;
      mem_if.data = base + 20'(k);
      if (k == stall_k) begin
        for (int s = 0; s < 3; s++) begin
          if (stall_kind == 1) i_halt = 1'b1; else i_da_halt = 1'b1;
          #1;
          check("stall da_valid", 32'(o_da_valid), 32'd0);
          check("stall data_ready", 32'(mem_if.data_ready), 32'd0);
          check("stall da_addr", 32'(o_da_addr), 32'({set, eo}));
          @(negedge clk);
        end
        i_halt = 1'b0; i_da_halt = 1'b0;
      end
      #1;
      check("da_valid", 32'(o_da_valid), 32'd1);
      check("da_addr", 32'(o_da_addr), 32'({set, eo}));
      check("da_mask", 32'(o_da_mask), 32'(exp_vic));
      check("da_data", 32'(o_da_data), 32'(base + 20'(k)));
      if (k == 1) begin
        check("missed valid", 32'(o_missed_word_valid), 32'd1);
        check("missed word", 32'(o_missed_word), 32'(base));
      end
      if (k == 2) check("missed pulse end", 32'(o_missed_word_valid), 32'd0);
      @(negedge clk);
    end
    mem_if.data_valid = 1'b0;
    if (meta_halt) i_ta_halt = 1'b1;
    #1;
    check("ta_valid", 32'(o_ta_valid), 32'd1);
    check("sa_valid", 32'(o_sa_valid), 32'd1);
    check("ta_addr", 32'(o_ta_addr), 32'(set));
    check("ta_data", 32'(o_ta_data), 32'(tag));
    check("ta_mask", 32'(o_ta_mask), 32'(exp_vic));
    check("sa_addr", 32'(o_sa_addr), 32'(set));
    check("sa_data", 32'(o_sa_data), 32'(exp_sa));
    check("sa_mask", 32'(o_sa_mask), 32'hF);
    if (meta_halt) begin
      @(negedge clk);
      #1;
      check("ta wait valid", 32'(o_ta_valid), 32'd1);
      check("sa committed", 32'(o_sa_valid), 32'd0);
      check("meta busy", 32'(o_miss_state), 32'd1);
      i_ta_halt = 1'b0;
    end
    @(negedge clk);
    #1 check_idle("post miss");
    check("da writes", 32'(da_cnt - da_start), 32'd16);
    $display("miss tag=%0h set=%0h off=%0h victim=%b sa=%h done", tag, set, off, exp_vic, exp_sa);
  endtask

  initial begin
    srst = 1'b1; i_halt = 1'b0; i_req_valid = 1'b0; i_cache_hit = 1'b0;
    i_tag = '0; i_set = '0; i_off = '0; i_sa_data = '0;
    i_da_halt = 1'b0; i_ta_halt = 1'b0; i_sa_halt = 1'b0;
    mem_if.req_ready = 1'b0; mem_if.data = '0; mem_if.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    #1 check_idle("reset");

    // Hit: nothing happens
    @(negedge clk);
    i_req_valid = 1'b1; i_cache_hit = 1'b1; i_tag = 8'h12; i_set = 4'h2; i_off = 4'h1;
    #1 check("hit ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_req_valid = 1'b0; i_cache_hit = 1'b0;
    #1 check_idle("hit");
    $display("hit tag=12 no action");

    // Stray beat while idle is ignored
    @(negedge clk);
    mem_if.data_valid = 1'b1; mem_if.data = 20'hABCDE;
    #1;
    check("idle beat da_valid", 32'(o_da_valid), 32'd0);
    check("idle beat ready", 32'(mem_if.data_ready), 32'd0);
    @(negedge clk);
    mem_if.data_valid = 1'b0;

    // Cold set 3, off 5, i_halt stall mid-fill
    run_miss(8'hA5, 4'd3, 4'd5, 12'h000, 4'b0001, 12'h004, 20'h10000, 6, 1, 1'b0, -1);
    // LRU: ages {2,3,1,0} -> victim way2, ages {3,0,2,1}; i_da_halt stall + i_ta_halt in META
    run_miss(8'h3C, 4'd7, 4'd0, 12'hDEC, 4'b0100, 12'hF35, 20'h20000, 9, 2, 1'b1, -1);
    // Wrap from offset 15; first invalid way is way2, valid ways age
    run_miss(8'h5A, 4'd9, 4'd15, 12'h03C, 4'b0100, 12'h13D, 20'h30000, -1, 0, 1'b0, -1);
    // Abort after 4 beats, then a complete refill
    run_miss(8'h77, 4'd1, 4'd2, 12'h000, 4'b0001, 12'h004, 20'h40000, -1, 0, 1'b0, 4);
    run_miss(8'h77, 4'd1, 4'd2, 12'h000, 4'b0001, 12'h004, 20'h50000, -1, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
